// File: rtl/mux_pkg.sv
// Shared types and limits for the N:1 pipelined selector.
package mux_pkg;

  localparam int MUX_N_MAX = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

endpackage

// File: rtl/mux_nt1_comb.sv
// Combinational N:1 channel selector; selects outside 0..N-1 yield zero.
module mux_nt1_comb #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0]   s,
  input  logic [N*WIDTH-1:0] I,
  output logic [WIDTH-1:0]   sel
);

  always_comb begin
    sel = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(s) == k) sel = I[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_nt1_pipe.sv
// N:1 selector with a two-entry skid buffer behind a valid/ready handshake.
// Optional sticky out-of-range flag enabled by defining MUX_SEL_ERR_EN.
module mux_nt1_pipe
  import mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   s,
  input  logic [N*WIDTH-1:0] I,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_SEL_ERR_EN
  ,
  output logic               sel_err,
  input  logic               err_clr
`endif
);

  if (N < 2 || N > MUX_N_MAX) begin : g_bad_n
    $error("mux_nt1_pipe: N out of supported range");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_out;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_skid_d;
  logic               r_skid_v;
  logic [WIDTH-1:0]   w_sel;
  logic               w_acc;
  logic               w_con;

  mux_nt1_comb #(.WIDTH(WIDTH), .N(N)) u_comb (
    .s   (s),
    .I   (I),
    .sel (w_sel)
  );

  // in_ready comes straight from the skid flop so out_ready never reaches upstream
  assign in_ready  = ~r_skid_v;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign w_acc     = in_valid & ~r_skid_v;
  assign w_con     = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_skid_d    <= '0;
      r_skid_v    <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_acc) begin
            r_state     <= ONE;
            r_out       <= w_sel;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_acc && w_con) begin
            r_out <= w_sel;
          end else if (w_acc) begin
            r_state  <= TWO;
            r_skid_d <= w_sel;
            r_skid_v <= 1'b1;
          end else if (w_con) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_con) begin
            r_state  <= ONE;
            r_out    <= r_skid_d;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_out_valid <= 1'b0;
          r_skid_v    <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic r_sel_err;
  logic w_oor;

  assign w_oor   = (32'(s) >= N);
  assign sel_err = r_sel_err;

  // a new error wins over a clear arriving in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 r_sel_err <= 1'b0;
    else if (w_acc && w_oor) r_sel_err <= 1'b1;
    else if (err_clr)        r_sel_err <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_mux_nt1_pipe.sv
// Self-checking bench for mux_nt1_pipe: N=4/WIDTH=32 main instance plus an
// N=5/WIDTH=8 instance for out-of-range selects; honours MUX_SEL_ERR_EN.
module tb_mux_nt1_pipe;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    s;
  logic [127:0]  I_bus;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [31:0]   out;

  logic [2:0]    s5;
  logic [39:0]   I5;
  logic          v5, rdy5, ov5, or5;
  logic [7:0]    out5;

  logic [31:0]   ch [4];
  logic [7:0]    ch5 [5];
  logic [31:0]   q [$];
  logic [31:0]   exp_v;
  int            n_pass = 0;
  int            n_chk  = 0;

`ifdef MUX_SEL_ERR_EN
  logic sel_err, err_clr, sel_err5, err_clr5;
`endif

  always #5 clk = ~clk;

  mux_nt1_pipe #(.WIDTH(32), .N(4)) u_dut (
    .clk(clk), .rst(rst), .s(s), .I(I_bus),
    .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(sel_err), .err_clr(err_clr)
`endif
  );

  mux_nt1_pipe #(.WIDTH(8), .N(5)) u_dut5 (
    .clk(clk), .rst(rst), .s(s5), .I(I5),
    .in_valid(v5), .in_ready(rdy5),
    .out(out5), .out_valid(ov5), .out_ready(or5)
`ifdef MUX_SEL_ERR_EN
    , .sel_err(sel_err5), .err_clr(err_clr5)
`endif
  );

  task automatic drive_bus();
    I_bus = {ch[3], ch[2], ch[1], ch[0]};
    I5    = {ch5[4], ch5[3], ch5[2], ch5[1], ch5[0]};
  endtask

  task automatic set_fixed();
    ch[0] = 32'hA0; ch[1] = 32'hB1; ch[2] = 32'hC2; ch[3] = 32'hD3;
    drive_bus();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; out_ready = 0; s = '0;
    v5 = 0; or5 = 0; s5 = '0;
`ifdef MUX_SEL_ERR_EN
    err_clr = 0; err_clr5 = 0;
`endif
    for (int k = 0; k < 5; k++) ch5[k] = 8'h10 + 8'(k);
    set_fixed();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (out !== 32'h0) $display("FAIL reset_out got=%h exp=0", out); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
`ifdef MUX_SEL_ERR_EN
    n_chk++; if (sel_err !== 1'b0) $display("FAIL reset_sel_err got=%b exp=0", sel_err); else n_pass++;
`endif
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    s = 2'd2; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    n_chk++; if (out !== 32'hC2) $display("FAIL single_out got=%h exp=c2", out); else n_pass++;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL single_in_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk); in_valid = 0;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_stream();
    q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = (c < 4); s = 2'(c); out_ready = 1;
      #1;
      if (c >= 1 && c <= 4) begin
        n_chk++; if (out_valid !== 1'b1) $display("FAIL stream_bubble cycle=%0d got=%b exp=1", c, out_valid); else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL stream_extra got=%h exp=none", out);
        else begin
          exp_v = q.pop_front();
          if (out !== exp_v) $display("FAIL stream_order got=%h exp=%h", out, exp_v); else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(ch[s]);
    end
    n_chk++; if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL stream_end left=%0d valid=%b exp=0/0", q.size(), out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    int nxt = 0;
    q.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      in_valid = (nxt < 4); s = 2'(nxt); out_ready = !(c >= 1 && c <= 3);
      #1;
      if (c == 2 || c == 3) begin
        n_chk++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, in_ready); else n_pass++;
        n_chk++; if (out !== 32'hA0) $display("FAIL stall_hold cycle=%0d got=%h exp=a0", c, out); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (in_ready !== 1'b1) $display("FAIL stall_reopen got=%b exp=1", in_ready); else n_pass++;
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL stall_dup got=%h exp=none", out);
        else begin
          exp_v = q.pop_front();
          if (out !== exp_v) $display("FAIL stall_order got=%h exp=%h", out, exp_v); else n_pass++;
        end
      end
      if (in_valid && in_ready) begin q.push_back(ch[s]); nxt++; end
    end
    n_chk++; if (nxt != 4 || q.size() != 0 || out_valid !== 1'b0)
      $display("FAIL stall_end sent=%0d left=%0d valid=%b exp=4/0/0", nxt, q.size(), out_valid);
    else n_pass++;
  endtask

  task automatic test_oor();
    @(negedge clk);
    drive_bus(); s5 = 3'd7; v5 = 1; or5 = 1;
    @(posedge clk); #1;
    n_chk++; if (out5 !== 8'h00) $display("FAIL oor_out got=%h exp=00", out5); else n_pass++;
    n_chk++; if (ov5 !== 1'b1) $display("FAIL oor_valid got=%b exp=1", ov5); else n_pass++;
`ifdef MUX_SEL_ERR_EN
    n_chk++; if (sel_err5 !== 1'b1) $display("FAIL oor_err_set got=%b exp=1", sel_err5); else n_pass++;
`endif
    @(negedge clk); s5 = 3'd4;
    @(posedge clk); #1;
    n_chk++; if (out5 !== 8'h14) $display("FAIL oor_in_range got=%h exp=14", out5); else n_pass++;
    @(negedge clk); v5 = 0;
    repeat (3) @(posedge clk);
    #1;
`ifdef MUX_SEL_ERR_EN
    n_chk++; if (sel_err5 !== 1'b1) $display("FAIL oor_err_hold got=%b exp=1", sel_err5); else n_pass++;
    @(negedge clk); err_clr5 = 1;
    @(negedge clk); err_clr5 = 0;
    n_chk++; if (sel_err5 !== 1'b0) $display("FAIL oor_err_clr got=%b exp=0", sel_err5); else n_pass++;
    s5 = 3'd5; v5 = 1; err_clr5 = 1;
    @(negedge clk); v5 = 0; err_clr5 = 0;
    n_chk++; if (sel_err5 !== 1'b1) $display("FAIL oor_err_prio got=%b exp=1", sel_err5); else n_pass++;
    n_chk++; if (out5 !== 8'h00) $display("FAIL oor_s5 got=%h exp=00", out5); else n_pass++;
    err_clr5 = 1;
    @(negedge clk); err_clr5 = 0;
`else
    @(negedge clk); s5 = 3'd5; v5 = 1;
    @(negedge clk); v5 = 0;
    n_chk++; if (out5 !== 8'h00) $display("FAIL oor_s5 got=%h exp=00", out5); else n_pass++;
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_in_two();
    set_fixed();
    @(negedge clk); s = 2'd0; in_valid = 1; out_ready = 0;
    @(negedge clk); s = 2'd1;
    @(negedge clk); in_valid = 0;
    #1;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL two_full got=%b exp=0", in_ready); else n_pass++;
    #1; rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL two_rst_valid got=%b exp=0", out_valid); else n_pass++;
    n_chk++; if (out !== 32'h0) $display("FAIL two_rst_out got=%h exp=0", out); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL two_rst_ready got=%b exp=1", in_ready); else n_pass++;
    @(negedge clk); rst = 1'b0; s = 2'd3; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    n_chk++; if (out !== 32'hD3 || out_valid !== 1'b1) $display("FAIL two_after got=%h/%b exp=d3/1", out, out_valid); else n_pass++;
    @(negedge clk); in_valid = 0;
    @(posedge clk); #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL two_no_stale got=%b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_random();
    q.delete();
    for (int c = 0; c < 10010; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      drive_bus();
      s = 2'($urandom_range(0, 3));
      in_valid  = (c < 10000) && ($urandom_range(0, 3) != 0);
      out_ready = (c >= 10000) || ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid === 1'b1 && out_ready) begin
        n_chk++;
        if (q.size() == 0) $display("FAIL rand_dup cycle=%0d got=%h exp=none", c, out);
        else begin
          exp_v = q.pop_front();
          if (out !== exp_v) $display("FAIL rand_order cycle=%0d got=%h exp=%h", c, out, exp_v); else n_pass++;
        end
      end
      if (in_valid && in_ready) q.push_back(ch[s]);
    end
    n_chk++; if (q.size() != 0 || out_valid !== 1'b0) $display("FAIL rand_lost left=%0d valid=%b exp=0/0", q.size(), out_valid); else n_pass++;
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_stall();
    test_oor();
    test_reset_in_two();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_nt1_pipe.md
# mux_nt1_pipe

Parametrised N-to-1 datapath selector with a registered, flow-controlled output. It is the next generation of the datapath's fixed two-input, 32-bit select mux. It picks one of N WIDTH-bit channels by a binary select and captures the result in a two-entry skid buffer behind a valid/ready handshake. Operand and writeback paths can stall without losing or duplicating a selected value.

## Interface
- WIDTH, 32, bit width of each channel and of the output
- N, 4, channel count, legal range 2..16; SEL_W = clog2(N) is derived and not overridable
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- s  in  SEL_W  binary channel select, sampled with in_valid
- I  in  N*WIDTH  flattened channels; channel k occupies I[k*WIDTH +: WIDTH]
- in_valid  in  1  upstream offers {s, I}
- in_ready  out  1  block can accept this cycle
- out  out  WIDTH  selected value, registered
- out_valid  out  1  out holds a value
- out_ready  in  1  downstream consumes out this cycle
- sel_err  out  1  sticky out-of-range select flag (MUX_SEL_ERR_EN only)
- err_clr  in  1  synchronous clear of sel_err (MUX_SEL_ERR_EN only)

## Operation
- Selected value: sel = (s < N) ? I[s] : 0. The out-of-range case exists only when N is not a power of two.
- Accept event: acc = in_valid & in_ready. Consume event: con = out_valid & out_ready.
- Storage: main register (out, out_valid) and skid register (skid_d, skid_v).
- in_ready = ~skid_v, driven directly from the flop with no combinational path from out_ready.
- State EMPTY (out_valid=0, skid_v=0):
  - acc → ONE, main ← sel.
- State ONE (out_valid=1, skid_v=0):
  - acc & con → stay ONE, main ← sel.
  - acc & ~con → TWO, skid ← sel.
  - ~acc & con → EMPTY.
- State TWO (out_valid=1, skid_v=1):
  - in_ready=0, so acc cannot occur.
  - con → ONE, main ← skid.
- Ordering is strict FIFO. No value is dropped or duplicated.
- out holds its value while out_valid & ~out_ready. Its value is don't-care when out_valid=0, but it is never X after reset.
- The state register is a 2-bit enum; encoding 2'b11 is illegal and recovers to EMPTY.

## Timing
- Reset values: out=0, out_valid=0, skid_v=0, skid_d=0, in_ready=1, sel_err=0. The reset is asynchronous assert and synchronous release; no accept occurs while rst=1.
- Latency: a value accepted at edge t is on out with out_valid=1 after edge t, i.e. one cycle.
- Throughput: one transfer per cycle when out_ready stays high.
- in_ready falls the cycle after a stall fills the skid register. It rises the cycle after the consume that drains it.
- Simultaneous accept and consume in ONE: both take effect on the same edge, and out_valid stays 1.
- rst asserted mid-operation discards both entries immediately; no partial values survive.

## Configuration
- MUX_SEL_ERR_EN defined:
  - sel_err and err_clr ports exist.
  - sel_err sets on any acc with s >= N and stays set until err_clr or rst.
  - Set has priority over err_clr in the same cycle.
- MUX_SEL_ERR_EN undefined:
  - sel_err and err_clr ports are absent.
  - Out-of-range selects still produce 0 silently.
- Datapath behaviour is identical in both builds.

## Structure
- Package mux_pkg holds:
  - the state typedef (EMPTY=2'b00, ONE=2'b01, TWO=2'b10);
  - the localparam MUX_N_MAX=16.
- Sub-module mux_nt1_comb: purely combinational N:1 selector with inputs s and I and output sel, including the zero fill for out-of-range selects. It is instantiated once.
- mux_nt1_pipe contains only the handshake state machine, the two registers and the error flag.

## Test plan
- Reset, then s=2 with I channels {0xA0,0xB1,0xC2,0xD3}, in_valid=1 and out_ready=1 → out=0xC2 and out_valid=1 one cycle later; in_ready stays 1.
- Streaming s=0,1,2,3 on consecutive cycles with out_ready=1 → out sequence 0xA0,0xB1,0xC2,0xD3 on consecutive cycles, with no bubbles.
- Drop out_ready for 3 cycles during a stream:
  - in_ready goes 0 after the second buffered value;
  - out holds steady;
  - after out_ready=1 returns, the values drain in order with no loss or duplicate.
- N=5, WIDTH=8, s=7 accepted → out=0x00; sel_err=1 with MUX_SEL_ERR_EN, held until an err_clr pulse; the same stimulus without the macro gives out=0x00 and no port.
- Assert rst while in state TWO → out_valid=0, out=0 and in_ready=1 immediately. After release, the next accept behaves as from EMPTY.
- Randomised valid/ready (at least 10k cycles) against a reference queue model → every accepted sel appears exactly once, in order.
